// File: rtl/wram_arbiter.sv
// wram_arbiter: request/acknowledge arbiter sharing a hi/lo byte-bank working RAM
// between CPU byte accesses and video word fetches. Video has priority and one
// video request can be held pending; every access takes IDLE -> ACC -> CAP.
module wram_arbiter #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [AW:0]     cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    output logic            cpu_ack,
    output logic [DW-1:0]   cpu_rdata,
    input  logic            vid_req,
    input  logic [AW-1:0]   vid_addr,
    output logic            vid_valid,
    output logic [2*DW-1:0] vid_data,
    output logic            vid_ovr,
    output logic [AW-1:0]   ram_addr,
    output logic            ram_we_hi,
    output logic            ram_we_lo,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata_hi,
    input  logic [DW-1:0]   ram_rdata_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CAP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_t;

    state_t        state;
    state_t        state_nxt;
    owner_t        owner;

    logic          vid_pend;
    logic [AW-1:0] vid_addr_q;
    logic          cpu_lsb_q;
    logic          cpu_we_q;

    logic          grant_vid;
    logic          grant_cpu;
    logic          cap_cpu;
    logic          cap_vid;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: any request leaves IDLE, the access then runs a fixed two cycles.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (vid_pend || vid_req || cpu_req) state_nxt = ACC;
            ACC:     state_nxt = CAP;
            CAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: grant selection in IDLE (video first) and capture qualifiers in CAP.
    always_comb begin
        grant_vid = (state == IDLE) && (vid_pend || vid_req);
        grant_cpu = (state == IDLE) && !(vid_pend || vid_req) && cpu_req;
        cap_cpu   = (state == CAP) && (owner == OWN_CPU);
        cap_vid   = (state == CAP) && (owner == OWN_VID);
    end

    // Grant register: owner, RAM address, write strobe and write data for the ACC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN_CPU;
            ram_addr  <= '0;
            ram_we_hi <= 1'b0;
            ram_we_lo <= 1'b0;
            ram_wdata <= '0;
            cpu_lsb_q <= 1'b0;
            cpu_we_q  <= 1'b0;
        end else begin
            ram_we_hi <= 1'b0;
            ram_we_lo <= 1'b0;
            if (grant_vid) begin
                owner    <= OWN_VID;
                ram_addr <= vid_pend ? vid_addr_q : vid_addr;
            end else if (grant_cpu) begin
                owner     <= OWN_CPU;
                ram_addr  <= cpu_addr[AW:1];
                ram_wdata <= cpu_wdata;
                ram_we_hi <= cpu_we & ~cpu_addr[0];
                ram_we_lo <= cpu_we &  cpu_addr[0];
                cpu_lsb_q <= cpu_addr[0];
                cpu_we_q  <= cpu_we;
            end
        end
    end

    // Video pending slot: one request buffered, a second one while still pending is an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_pend   <= 1'b0;
            vid_addr_q <= '0;
            vid_ovr    <= 1'b0;
        end else if (grant_vid && vid_pend) begin
            // Slot frees this cycle, so a simultaneous strobe refills it.
            vid_pend <= vid_req;
            if (vid_req)
                vid_addr_q <= vid_addr;
        end else if (grant_vid) begin
            // Strobe granted directly from IDLE; nothing to buffer.
            vid_pend <= 1'b0;
        end else if (vid_req) begin
            if (vid_pend) begin
                vid_ovr <= 1'b1;
            end else begin
                vid_pend   <= 1'b1;
                vid_addr_q <= vid_addr;
            end
        end
    end

    // Completion: capture RAM data at the end of CAP and pulse ack/valid in the following IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_ack   <= 1'b0;
            vid_valid <= 1'b0;
            cpu_rdata <= '0;
            vid_data  <= '0;
        end else begin
            cpu_ack   <= cap_cpu;
            vid_valid <= cap_vid;
            if (cap_cpu && !cpu_we_q)
                cpu_rdata <= cpu_lsb_q ? ram_rdata_lo : ram_rdata_hi;
            if (cap_vid)
                vid_data <= {ram_rdata_hi, ram_rdata_lo};
        end
    end

endmodule

// File: tb/tb_wram_arbiter.sv
// tb_wram_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run against a byte-addressed shadow memory reference model.
module tb_wram_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            cpu_req;
    logic            cpu_we;
    logic [AW:0]     cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic            cpu_ack;
    logic [DW-1:0]   cpu_rdata;
    logic            vid_req;
    logic [AW-1:0]   vid_addr;
    logic            vid_valid;
    logic [2*DW-1:0] vid_data;
    logic            vid_ovr;
    logic [AW-1:0]   ram_addr;
    logic            ram_we_hi;
    logic            ram_we_lo;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata_hi;
    logic [DW-1:0]   ram_rdata_lo;

    wram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
        .vid_ovr(vid_ovr),
        .ram_addr(ram_addr), .ram_we_hi(ram_we_hi), .ram_we_lo(ram_we_lo), .ram_wdata(ram_wdata),
        .ram_rdata_hi(ram_rdata_hi), .ram_rdata_lo(ram_rdata_lo)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM pair with a backdoor for bulk fill and single-word preload.
    logic [DW-1:0] mem_hi [0:(1<<AW)-1];
    logic [DW-1:0] mem_lo [0:(1<<AW)-1];
    logic          bd_fill = 1'b0;
    int            bd_seed = 0;
    logic          bd_wr   = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_hi   = '0;
    logic [DW-1:0] bd_lo   = '0;

    function automatic logic [7:0] pat(input int b, input int seed);
        return 8'(((b * 29) + (seed * 113) + ((b >> 4) * 7)) ^ (seed >> 1));
    endfunction

    always @(posedge clk) begin
        if (bd_fill) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem_hi[i] <= pat(2 * i, bd_seed);
                mem_lo[i] <= pat(2 * i + 1, bd_seed);
            end
        end else if (bd_wr) begin
            mem_hi[bd_addr] <= bd_hi;
            mem_lo[bd_addr] <= bd_lo;
        end else begin
            if (ram_we_hi) mem_hi[ram_addr] <= ram_wdata;
            if (ram_we_lo) mem_lo[ram_addr] <= ram_wdata;
        end
        ram_rdata_hi <= mem_hi[ram_addr];
        ram_rdata_lo <= mem_lo[ram_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU access with no video traffic; reports latency, strobes seen and ACC address.
    task automatic cpu_xfer(input logic we, input logic [AW:0] addr, input logic [DW-1:0] wd,
                            output int lat, output int n_hi, output int n_lo,
                            output logic [AW-1:0] acc_addr, output logic got);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        lat = 0; n_hi = 0; n_lo = 0; got = 1'b0; acc_addr = '0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (ram_we_hi) n_hi++;
            if (ram_we_lo) n_lo++;
            if (lat == 1) acc_addr = ram_addr;
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0;
    endtask

    // CPU access plus up to two one-cycle video strobes at given cycle offsets (-1 = none).
    task automatic window(input logic we, input logic [AW:0] addr, input logic [DW-1:0] wd,
                          input int vc1, input logic [AW-1:0] va1,
                          input int vc2, input logic [AW-1:0] va2,
                          output int ack_c, output int n_ack, output logic [DW-1:0] rd,
                          output int v1_c, output int v2_c, output int n_val,
                          output logic [2*DW-1:0] vd1, output logic [2*DW-1:0] vd2);
        ack_c = -1; n_ack = 0; rd = '0; v1_c = -1; v2_c = -1; n_val = 0; vd1 = '0; vd2 = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        vid_req = (vc1 == 0); vid_addr = va1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (cpu_ack) begin
                n_ack++;
                if (ack_c < 0) begin ack_c = c; rd = cpu_rdata; end
                cpu_req = 1'b0;
            end
            if (vid_valid) begin
                n_val++;
                if (n_val == 1) begin v1_c = c; vd1 = vid_data; end
                else if (n_val == 2) begin v2_c = c; vd2 = vid_data; end
            end
            vid_req = 1'b0;
            if (c == vc1) begin vid_req = 1'b1; vid_addr = va1; end
            if (c == vc2) begin vid_req = 1'b1; vid_addr = va2; end
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
    endtask

    typedef struct {
        logic          we;
        logic [AW:0]   addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        int            exp_hi;
        int            exp_lo;
        logic [AW-1:0] exp_ram_addr;
    } cpu_vec_t;

    cpu_vec_t vec [10];

    logic [7:0]    shadow [0:(2<<AW)-1];
    logic [AW-1:0] vq [$];

    initial begin
        int              lat, n_hi, n_lo, ack_c, n_ack, v1_c, v2_c, n_val, gap, vphase, max_lat;
        int              n_ack5, n_val5;
        logic            got, cpu_busy, cur_we, draining;
        logic [AW-1:0]   acc_addr, a;
        logic [DW-1:0]   rd, exp_rdata, cur_wdata;
        logic [AW:0]     cur_addr;
        logic [2*DW-1:0] vd1, vd2, exp_vid;

        vec[0] = '{1'b1, 12'h001, 8'h5A, 8'h00, 0, 1, 11'h000};
        vec[1] = '{1'b0, 12'h001, 8'h00, 8'h5A, 0, 0, 11'h000};
        vec[2] = '{1'b1, 12'h000, 8'h3C, 8'h5A, 1, 0, 11'h000};
        vec[3] = '{1'b0, 12'h000, 8'h00, 8'h3C, 0, 0, 11'h000};
        vec[4] = '{1'b0, 12'h001, 8'h00, 8'h5A, 0, 0, 11'h000};
        vec[5] = '{1'b1, 12'hFFF, 8'h81, 8'h5A, 0, 1, 11'h7FF};
        vec[6] = '{1'b1, 12'hFFE, 8'h7E, 8'h5A, 1, 0, 11'h7FF};
        vec[7] = '{1'b0, 12'hFFF, 8'h00, 8'h81, 0, 0, 11'h7FF};
        vec[8] = '{1'b0, 12'hFFE, 8'h00, 8'h7E, 0, 0, 11'h7FF};
        vec[9] = '{1'b1, 12'h246, 8'hC3, 8'h7E, 1, 0, 11'h123};

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        tick(); tick(); tick();

        // Reset state.
        check("rst cpu_ack", cpu_ack, 0);
        check("rst vid_valid", vid_valid, 0);
        check("rst cpu_rdata", cpu_rdata, 0);
        check("rst vid_data", vid_data, 0);
        check("rst vid_ovr", vid_ovr, 0);
        check("rst ram_we", {ram_we_hi, ram_we_lo}, 0);
        check("rst ram_addr", ram_addr, 0);
        reset = 1'b0;

        bd_fill = 1'b1; bd_seed = 1;
        tick();
        bd_fill = 1'b0;

        // Directed CPU vectors: fixed 3-cycle latency, single correct strobe, byte select.
        for (int i = 0; i < 10; i++) begin
            cpu_xfer(vec[i].we, vec[i].addr, vec[i].wdata, lat, n_hi, n_lo, acc_addr, got);
            check($sformatf("vec%0d ack_seen", i), got, 1);
            check($sformatf("vec%0d latency", i), lat, 3);
            check($sformatf("vec%0d we_hi_cycles", i), n_hi, vec[i].exp_hi);
            check($sformatf("vec%0d we_lo_cycles", i), n_lo, vec[i].exp_lo);
            check($sformatf("vec%0d acc_addr", i), acc_addr, vec[i].exp_ram_addr);
            check($sformatf("vec%0d cpu_rdata", i), cpu_rdata, vec[i].exp_rdata);
            tick();
            check($sformatf("vec%0d ack_one_cycle", i), cpu_ack, 0);
        end

        // Video fetch of a preloaded word.
        bd_wr = 1'b1; bd_addr = 11'h123; bd_hi = 8'hAB; bd_lo = 8'hCD;
        tick();
        bd_wr = 1'b0;
        vid_req = 1'b1; vid_addr = 11'h123;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            vid_req = 1'b0;
            lat++;
            if (vid_valid) got = 1'b1;
        end
        check("vid latency", lat, 3);
        check("vid data", vid_data, 16'hABCD);
        tick();
        check("vid valid_one_cycle", vid_valid, 0);

        // Simultaneous CPU and video request: video first, CPU ack three cycles after valid.
        window(1'b0, 12'h246, 8'h00, 0, 11'h123, -1, 11'h000,
               ack_c, n_ack, rd, v1_c, v2_c, n_val, vd1, vd2);
        check("prio vid_valid_cycle", v1_c, 3);
        check("prio vid_data", vd1, 16'hABCD);
        check("prio cpu_ack_cycle", ack_c, 6);
        check("prio cpu_rdata", rd, 8'hAB);
        check("prio ack_count", n_ack, 1);

        // Video strobe during CPU ACC becomes pending and is served next.
        window(1'b1, 12'h247, 8'h11, 1, 11'h123, -1, 11'h000,
               ack_c, n_ack, rd, v1_c, v2_c, n_val, vd1, vd2);
        check("pend cpu_ack_cycle", ack_c, 3);
        check("pend cpu_rdata_held", rd, 8'hAB);
        check("pend vid_valid_cycle", v1_c, 6);
        check("pend vid_data", vd1, 16'hAB11);
        check("pend valid_count", n_val, 1);
        check("pend vid_ovr", vid_ovr, 0);

        // Second strobe in the cycle the pending one is granted: refills the slot, no overrun.
        window(1'b0, 12'h000, 8'h00, 1, 11'h123, 3, 11'h7FF,
               ack_c, n_ack, rd, v1_c, v2_c, n_val, vd1, vd2);
        check("refill cpu_ack_cycle", ack_c, 3);
        check("refill cpu_rdata", rd, 8'h3C);
        check("refill valid1_cycle", v1_c, 6);
        check("refill valid1_data", vd1, 16'hAB11);
        check("refill valid2_cycle", v2_c, 9);
        check("refill valid2_data", vd2, 16'h7E81);
        check("refill vid_ovr", vid_ovr, 0);

        // Second strobe while still pending and not granted: overrun, first fetch kept.
        window(1'b0, 12'h001, 8'h00, 1, 11'h7FF, 2, 11'h123,
               ack_c, n_ack, rd, v1_c, v2_c, n_val, vd1, vd2);
        check("ovr cpu_ack_cycle", ack_c, 3);
        check("ovr cpu_rdata", rd, 8'h5A);
        check("ovr valid_cycle", v1_c, 6);
        check("ovr valid_data", vd1, 16'h7E81);
        check("ovr valid_count", n_val, 1);
        check("ovr vid_ovr", vid_ovr, 1);

        // Reset in the ACC cycle of a CPU write aborts it.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h002; cpu_wdata = 8'h99;
        tick();
        check("abort acc_we_hi", ram_we_hi, 1);
        reset = 1'b1;
        tick();
        check("abort ram_we", {ram_we_hi, ram_we_lo}, 0);
        check("abort cpu_ack", cpu_ack, 0);
        check("abort vid_valid", vid_valid, 0);
        check("abort cpu_rdata", cpu_rdata, 0);
        check("abort vid_data", vid_data, 0);
        check("abort vid_ovr", vid_ovr, 0);
        check("abort ram_addr", ram_addr, 0);
        reset = 1'b0;
        cpu_req = 1'b0;
        n_ack5 = 0; n_val5 = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (cpu_ack) n_ack5++;
            if (vid_valid) n_val5++;
        end
        check("abort no_ack_after", n_ack5, 0);
        check("abort no_valid_after", n_val5, 0);

        // Randomized traffic against the shadow memory.
        bd_fill = 1'b1; bd_seed = 7;
        tick();
        bd_fill = 1'b0;
        for (int b = 0; b < (2 << AW); b++) shadow[b] = pat(b, 7);
        cpu_busy = 1'b0; gap = 0; max_lat = 0; lat = 0; draining = 1'b0;
        cur_we = 1'b0; cur_addr = '0; cur_wdata = '0;
        exp_rdata = '0; exp_vid = '0;
        vphase = $urandom_range(0, 7);
        for (int cyc = 0; cyc < 10040; cyc++) begin
            tick();
            draining = (cyc >= 10000);
            if (cpu_busy) lat++;
            if (cpu_ack) begin
                check("rnd ack_expected", cpu_busy, 1);
                if (cpu_busy) begin
                    if (cur_we) shadow[cur_addr] = cur_wdata;
                    else exp_rdata = shadow[cur_addr];
                    n_cmp++;
                    if (lat > 6) begin
                        n_err++;
                        $display("FAIL rnd cpu_latency: got %0d cycles, limit 6", lat);
                    end
                    if (lat > max_lat) max_lat = lat;
                end
                cpu_busy = 1'b0;
                gap = $urandom_range(0, 3);
            end
            check("rnd cpu_rdata", cpu_rdata, exp_rdata);
            if (vid_valid) begin
                check("rnd valid_expected", vq.size() != 0, 1);
                if (vq.size() != 0) begin
                    a = vq.pop_front();
                    exp_vid = {shadow[{a, 1'b0}], shadow[{a, 1'b1}]};
                end
            end
            check("rnd vid_data", vid_data, exp_vid);

            vid_req = 1'b0;
            if (vphase == 0 && !draining) begin
                vid_req = 1'b1;
                vid_addr = AW'($urandom);
                vq.push_back(vid_addr);
            end
            vphase = (vphase + 1) % 8;

            if (!cpu_busy) begin
                if (gap == 0 && !draining) begin
                    cur_we = 1'($urandom);
                    cur_addr = ($urandom_range(0, 1) == 1) ? (AW+1)'($urandom_range(0, 31))
                                                           : (AW+1)'($urandom);
                    cur_wdata = DW'($urandom);
                    cpu_req = 1'b1; cpu_we = cur_we; cpu_addr = cur_addr; cpu_wdata = cur_wdata;
                    cpu_busy = 1'b1;
                    lat = 0;
                end else begin
                    cpu_req = 1'b0;
                    if (gap > 0) gap--;
                end
            end
        end
        check("rnd video_drained", vq.size(), 0);
        check("rnd cpu_drained", cpu_busy, 0);
        check("rnd vid_ovr", vid_ovr, 0);
        $display("random run: max CPU req->ack latency %0d cycles", max_lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
